// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch FSM states, PC op codes shared with the program counter, NOP default.
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;
  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC1   = 2'b01;
  localparam logic [1:0] PC_INC2   = 2'b10;
  localparam logic [1:0] PC_OFFSET = 2'b11;
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage FSM; handshakes with instruction memory, steers the PC, squashes on redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] pc_value,
  output logic                  pc_enable,
  output logic [1:0]            pc_op,
  output logic [DATA_WIDTH-1:0] pc_offset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_offset,
  input  logic                  decode_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] instr_pc
);
  state_t state_q;
  logic discard_q;
  logic redirect, fetch_ok;
  logic [DATA_WIDTH-1:0] addr_issue;
  assign redirect  = reset_n & branch_taken;
  assign fetch_ok  = reset_n & (state_q == FETCH) & imem_req & imem_ready & ~discard_q & ~branch_taken;
  assign pc_enable = redirect | fetch_ok;
  assign pc_op     = redirect ? PC_OFFSET : fetch_ok ? PC_INC1 : PC_HOLD;
  assign pc_offset = redirect ? branch_offset : '0;
  // A redirect moves the PC on this edge, so the new request is deferred a cycle to latch the target.
  assign addr_issue = branch_taken ? imem_addr : pc_value;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      instr_pc    <= '0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= FETCH;
          imem_req  <= ~branch_taken;
          imem_addr <= addr_issue;
        end
        FETCH: begin
          if (!imem_req) begin
            imem_req  <= ~branch_taken;
            imem_addr <= addr_issue;
          end else if (imem_ready && (discard_q || branch_taken)) begin
            discard_q <= 1'b0;
            imem_req  <= ~branch_taken;
            imem_addr <= addr_issue;
          end else if (imem_ready) begin
            instr_out   <= imem_rdata;
            instr_pc    <= imem_addr;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state_q     <= VALID;
          end else if (branch_taken) begin
            discard_q <= 1'b1;
          end
        end
        VALID: begin
          if (branch_taken || decode_ready) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state_q     <= FETCH;
            imem_req    <= ~branch_taken;
            imem_addr   <= addr_issue;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of the fetch unit against a transaction-level model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] pc_value = '0, pc_offset, imem_addr, imem_rdata = '0, branch_offset = '0, instr_out, instr_pc;
  logic [1:0] pc_op;
  logic pc_enable, imem_req, imem_ready = 1'b0, branch_taken = 1'b0, decode_ready = 1'b0, instr_valid;
  int checks = 0, fails = 0;
  int m_pc, m_req_addr, m_held, m_held_pc;
  bit m_started, m_stale;
  logic [15:0] last_rdata;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .pc_value(pc_value), .pc_enable(pc_enable), .pc_op(pc_op),
    .pc_offset(pc_offset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .decode_ready(decode_ready), .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_fetch_ok();
    return m_req_addr >= 0 && imem_ready && !m_stale && !branch_taken;
  endfunction

  task automatic m_issue(input int a);
    m_req_addr = branch_taken ? -1 : a;
  endtask

  // Advance the model across the posedge that just passed, using the inputs that were applied to it.
  task automatic step();
    int old_pc = m_pc;
    bit ok = m_fetch_ok();
    m_pc = branch_taken ? (m_pc + int'(branch_offset)) & 32'hFFFF : ok ? (m_pc + 1) & 32'hFFFF : m_pc;
    if (!m_started) begin
      m_started = 1;
      m_issue(old_pc);
    end else if (m_req_addr >= 0) begin
      if (imem_ready && (m_stale || branch_taken)) begin
        m_stale = 0;
        m_issue(old_pc);
      end else if (imem_ready) begin
        m_held = int'(imem_rdata);
        m_held_pc = m_req_addr;
        m_req_addr = -1;
      end else if (branch_taken) m_stale = 1;
    end else if (m_held >= 0) begin
      if (branch_taken || decode_ready) begin
        m_held = -1;
        m_issue(old_pc);
      end
    end else m_issue(old_pc);
  endtask

  task automatic check();
    bit ok = m_fetch_ok();
    chk("imem_req", imem_req, m_req_addr >= 0);
    if (m_req_addr >= 0) chk("imem_addr", imem_addr, m_req_addr);
    chk("instr_valid", instr_valid, m_held >= 0);
    chk("instr_out", instr_out, m_held >= 0 ? m_held : 0);
    chk("instr_pc", instr_pc, m_held_pc);
    chk("pc_enable", pc_enable, branch_taken || ok);
    chk("pc_op", pc_op, branch_taken ? 3 : ok ? 1 : 0);
    chk("pc_offset", pc_offset, branch_taken ? branch_offset : 0);
  endtask

  task automatic cycle(input bit rdy, input bit dec, input bit br, input logic [15:0] off);
    @(negedge clk);
    step();
    pc_value = m_pc[15:0];
    imem_ready = rdy;
    imem_rdata = 16'($urandom);
    decode_ready = dec;
    branch_taken = br;
    branch_offset = off;
    #1;
    check();
  endtask

  task automatic do_reset(input logic [15:0] start, input bit br, input logic [15:0] off);
    @(negedge clk);
    reset_n = 1'b0;
    branch_taken = 1'b1;
    branch_offset = 16'h1234;
    pc_value = start;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_pc_enable", pc_enable, 0);
    m_pc = int'(start); m_req_addr = -1; m_held = -1; m_held_pc = 0; m_started = 0; m_stale = 0;
    @(negedge clk);
    chk("rst_instr_out", instr_out, NOP_INSTR_DEFAULT);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_imem_addr", imem_addr, 0);
    reset_n = 1'b1;
    imem_ready = 1'b0;
    decode_ready = 1'b0;
    branch_taken = br;
    branch_offset = off;
    #1;
    check();
  endtask

  initial begin
    do_reset(16'h0000, 0, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 1, 0, 16'h0000);
      if (i % 2 == 1) begin
        chk("a_addr", imem_addr, (i - 1) / 2);
        chk("a_op_inc", pc_op, 1);
      end else begin
        chk("a_valid", instr_valid, 1);
        chk("a_ipc", instr_pc, i / 2 - 1);
        chk("a_op_hold", pc_op, 0);
      end
    end
    do_reset(16'h0010, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 16'h0000);
      chk("w_addr", imem_addr, 16'h0010);
      chk("w_req", imem_req, 1);
      chk("w_pcen", pc_enable, 0);
    end
    cycle(1, 1, 0, 16'h0000);
    chk("w_op_inc", pc_op, 1);
    last_rdata = imem_rdata;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 16'h0000);
      chk("s_instr", instr_out, last_rdata);
      chk("s_ipc", instr_pc, 16'h0010);
      chk("s_pcen", pc_enable, 0);
      chk("s_req", imem_req, 0);
    end
    cycle(0, 1, 1, 16'h0005);
    chk("vb_op", pc_op, 3);
    chk("vb_off", pc_offset, 16'h0005);
    cycle(0, 0, 0, 16'h0000);
    chk("vb_squash", instr_valid, 0);
    chk("vb_nop", instr_out, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    chk("vb_addr", imem_addr, 16'h0016);
    cycle(0, 0, 1, 16'hFFFC);
    chk("fb_op", pc_op, 3);
    chk("fb_off", pc_offset, 16'hFFFC);
    cycle(0, 0, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    chk("fb_drop_pcen", pc_enable, 0);
    cycle(0, 1, 0, 16'h0000);
    chk("fb_drop_valid", instr_valid, 0);
    chk("fb_addr", imem_addr, 16'h0012);
    cycle(1, 1, 1, 16'h0100);
    chk("rb_op", pc_op, 3);
    cycle(0, 1, 0, 16'h0000);
    chk("rb_drop_valid", instr_valid, 0);
    cycle(0, 1, 0, 16'h0000);
    chk("rb_addr", imem_addr, 16'h0112);
    chk("rb_req", imem_req, 1);
    do_reset(16'hFFFF, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    chk("wrap_addr0", imem_addr, 16'hFFFF);
    cycle(1, 1, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    chk("wrap_addr1", imem_addr, 16'h0000);
    do_reset(16'h0040, 1, 16'h0008);
    chk("idle_op", pc_op, 3);
    cycle(0, 1, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    chk("idle_addr", imem_addr, 16'h0048);
    do_reset(16'($urandom), 0, 16'h0000);
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit RISC core. It sits directly downstream of the program counter, which it also steers.
- Reads the PC value, runs a req/ready handshake with instruction memory, and holds the returned word in an instruction register for decode.
- Drives the PC's enable/op/offset controls: +1 after each accepted fetch, PC+offset on a branch redirect.
- Squashes in-flight or held instructions on redirect.

Parameters:
- DATA_WIDTH, 16, instruction and address width.
- NOP_INSTR, 16'h0000, value driven on instr_out while instr_valid=0 and after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- pc_value  in  16  current PC register value from the program counter.
- pc_enable  out  1  PC update enable (combinational).
- pc_op  out  2  PC operation: 00 hold, 01 +1, 10 +2 (unused here), 11 +offset (combinational).
- pc_offset  out  16  offset for pc_op=11; equals branch_offset when redirecting, else 0.
- imem_req  out  1  instruction memory read request (registered).
- imem_addr  out  16  read address, held stable while imem_req=1 (registered).
- imem_rdata  in  16  read data, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  single-cycle redirect request from execute.
- branch_offset  in  16  signed offset applied to pc_value on redirect.
- decode_ready  in  1  decode accepts instr_out this cycle.
- instr_valid  out  1  instr_out/instr_pc hold a live instruction (registered).
- instr_out  out  16  instruction register.
- instr_pc  out  16  address the held instruction was fetched from.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr_out=NOP_INSTR, instr_pc=0, discard=0. pc_enable=0 while reset_n=0.
- States: IDLE, FETCH, VALID.
- IDLE: lasts one cycle after reset release, then goes to FETCH.
- Entering FETCH: imem_addr<=pc_value, imem_req<=1.
- FETCH, imem_req and imem_addr: held unchanged until imem_ready=1. No address change mid-transaction, including on redirect.
- FETCH, imem_ready=1 with discard=0 and branch_taken=0:
  - instr_out<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0.
  - Drives pc_enable=1, pc_op=01 that cycle, so PC increments on the same edge.
  - Next state VALID.
- FETCH, imem_ready=1 with discard=1 or branch_taken=1:
  - Data dropped, no +1, discard<=0.
  - Re-enters FETCH next cycle: imem_addr<=pc_value, imem_req<=1, so it re-latches the redirected PC.
- FETCH, branch_taken=1 with imem_ready=0: discard<=1; the transaction runs to completion, then is dropped.
- VALID, decode_ready=1: instruction consumed. instr_valid<=0, instr_out<=NOP_INSTR, next state FETCH.
- VALID, decode_ready=0: everything held and pc_enable=0 (stall).
- Redirect (branch_taken=1) in any state except reset:
  - Drives pc_enable=1, pc_op=11, pc_offset=branch_offset that cycle.
  - Takes priority over the +1 and over decode_ready.
- Redirect in VALID: the held instruction is squashed (instr_valid<=0, instr_out<=NOP_INSTR, not delivered to decode even if decode_ready=1); next state FETCH.
- Redirect in IDLE: the PC is redirected; next state FETCH as usual.
- Otherwise pc_enable=0, pc_op=00.
- Arithmetic: performed by the PC (16-bit, wraps modulo 2^16). This block only forwards branch_offset. Fetch at 16'hFFFF followed by +1 wraps to 16'h0000 with no special handling.
- Latency: with memory ready in the same cycle as the request, each instruction takes 2 cycles (FETCH+VALID). Wait states extend FETCH.
- Reset mid-transaction: imem_req drops immediately (async). Memory must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - state encoding for IDLE/FETCH/VALID;
  - PC op constants PC_HOLD=00, PC_INC1=01, PC_INC2=10, PC_OFFSET=11, shared with the program counter;
  - NOP_INSTR default.
- No sub-module: one FSM plus registers.

Test Plan:
- Reset release, memory always ready, decode always ready, pc_value stepping 0,1,2 -> imem_addr 0,1,2 on alternate cycles; instr_valid pulses every 2nd cycle; pc_op=01 exactly on each imem_ready cycle.
- imem_ready held low 3 cycles at addr 16'h0010 -> imem_req=1 and imem_addr=16'h0010 stable all 3 cycles; pc_enable=0 until ready; instr_out=rdata afterwards.
- VALID with decode_ready=0 for 4 cycles -> instr_valid, instr_out, instr_pc unchanged; pc_enable=0; no new imem_req.
- branch_taken=1, branch_offset=16'hFFFC during a FETCH wait -> pc_op=11 and pc_offset=16'hFFFC that cycle; completing data dropped (instr_valid stays 0); next imem_addr equals the new pc_value.
- branch_taken and decode_ready together in VALID -> instruction squashed, instr_out=NOP_INSTR, pc_op=11, next state FETCH.
- Same-cycle imem_ready and branch_taken -> pc_op=11 (not 01), data dropped; reset_n pulsed low mid-FETCH -> imem_req=0 and instr_valid=0 immediately.
